fpna_config_chain: RTL

Parametrised successor to the single-bit configuration bitstream shifter in the neurochip top. Shifts configuration in SHIFT_W bits per clock into a CHAIN_LEN-bit scan register. A length-checked commit copies it to an active configuration register driving the fabric. A readback capture reloads the scan register from the active configuration for shift-out verification.

---
 rtl/fpna_config_chain_if.sv | 25 ++
 rtl/fpna_config_chain.sv | 65 ++++++
 2 files changed

// File: rtl/fpna_config_chain_if.sv
// Configuration chain bus: shift-in beats, commit/readback requests and fabric-side status.
interface fpna_config_chain_if #(
  parameter int CHAIN_LEN = 256,
  parameter int SHIFT_W   = 1
);
  logic                 config_en;
  logic [SHIFT_W-1:0]   bs_in;
  logic [SHIFT_W-1:0]   bs_out;
  logic                 commit;
  logic                 readback;
  logic [CHAIN_LEN-1:0] cfg_active;
  logic                 cfg_valid;
  logic                 cfg_full;
  logic                 cfg_err;

  modport master (
    output config_en, bs_in, commit, readback,
    input  bs_out, cfg_active, cfg_valid, cfg_full, cfg_err
  );

  modport slave (
    input  config_en, bs_in, commit, readback,
    output bs_out, cfg_active, cfg_valid, cfg_full, cfg_err
  );
endinterface

// File: rtl/fpna_config_chain.sv
// Multi-bit configuration scan chain with length-checked commit into the active
// configuration and readback capture for shift-out verification.
module fpna_config_chain #(
  parameter int                   CHAIN_LEN = 256,
  parameter int                   SHIFT_W   = 1,
  parameter logic [CHAIN_LEN-1:0] RESET_CFG = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  fpna_config_chain_if.slave   bus
);
  localparam int BEATS = CHAIN_LEN / SHIFT_W;
  localparam int CW    = $clog2(BEATS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(BEATS);
  localparam logic [CW-1:0] CNT_OVR  = CW'(BEATS + 1);

  typedef struct packed {
    logic shift;
    logic commit;
    logic readback;
  } req_t;

  logic [CHAIN_LEN-1:0] sr, cfg_q;
  logic [CW-1:0]        cnt;
  logic                 valid_q, err_q, full;
  req_t                 req;

  // Priority decode: a shift beat always wins; commit beats readback.
  assign req.shift    = bus.config_en;
  assign req.commit   = !bus.config_en && bus.commit;
  assign req.readback = !bus.config_en && !bus.commit && bus.readback;
  assign full         = (cnt == CNT_FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      cfg_q   <= RESET_CFG;
      cnt     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (req.shift) begin
      sr <= (sr << SHIFT_W) | CHAIN_LEN'(bus.bs_in);
      if (cnt != CNT_OVR) cnt <= cnt + 1'b1;
      // A request colliding with a beat is dropped and flagged.
      if (bus.commit || bus.readback) err_q <= 1'b1;
    end else if (req.commit) begin
      if (full) begin
        cfg_q   <= sr;
        valid_q <= 1'b1;
      end else begin
        err_q <= 1'b1;
      end
      cnt <= '0;
    end else if (req.readback) begin
      sr  <= cfg_q;
      cnt <= '0;
    end
  end

  assign bus.bs_out     = sr[CHAIN_LEN-1 -: SHIFT_W];
  assign bus.cfg_active = cfg_q;
  assign bus.cfg_valid  = valid_q;
  assign bus.cfg_full   = full;
  assign bus.cfg_err    = err_q;
endmodule
